// File: rtl/ltch_bank_ctrl_if.sv
// Signals between the two write requesters (APB port A, 1553B port B),
// the latch write sequencer and the latch array it drives.
interface ltch_bank_ctrl_if #(
  parameter int DW   = 16,
  parameter int NREG = 8,
  parameter int AW   = 4
);
  logic            a_req;
  logic [AW-1:0]   a_addr;
  logic [DW-1:0]   a_data;
  logic            a_ack;
  logic            b_req;
  logic [AW-1:0]   b_addr;
  logic [DW-1:0]   b_data;
  logic            b_ack;
  logic [NREG-1:0] ltch_en;
  logic [DW-1:0]   ltch_data;
  logic            busy;
  logic            addr_err;

  // Handshake: req rises with addr/data stable and holds until the one-cycle
  // ack is seen; the write is accepted only when the sequencer is idle.
  modport master (
    output a_req, a_addr, a_data, b_req, b_addr, b_data,
    input  a_ack, b_ack, ltch_en, ltch_data, busy, addr_err
  );

  modport slave (
    input  a_req, a_addr, a_data, b_req, b_addr, b_data,
    output a_ack, b_ack, ltch_en, ltch_data, busy, addr_err
  );
endinterface

// File: rtl/ltch_bank_ctrl.sv
// Round-robin write sequencer for a bank of latch-based configuration words:
// data setup, enable open for OPEN_CYC cycles, data hold, then ack.
module ltch_bank_ctrl #(
  parameter int DW       = 16,
  parameter int NREG     = 8,
  parameter int AW       = 4,
  parameter int OPEN_CYC = 1
) (
  input  logic           clk,
  input  logic           rst,
  ltch_bank_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SETUP, OPEN, HOLD} state_t;

  localparam logic [AW:0] NREG_W  = (AW+1)'(NREG);
  localparam logic [3:0]  OPEN_LD = 4'(OPEN_CYC - 1);

  state_t          state_q, state_d;
  logic [3:0]      open_cnt;
  logic            rr_last;   // 1: port B won the most recent grant
  logic            owner_b;
  logic [AW-1:0]   addr_q;
  logic            grant, grant_b;
  logic            addr_ok;
  logic [NREG-1:0] en_dec;

  logic [NREG-1:0] en_q;
  logic [DW-1:0]   data_q;
  logic            a_ack_q, b_ack_q, busy_q, err_q;

  assign addr_ok = ({1'b0, addr_q} < NREG_W);

  always_comb begin
    en_dec = '0;
    for (int i = 0; i < NREG; i++) begin
      if (addr_q == AW'(i)) en_dec[i] = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    grant_b = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.a_req || bus.b_req) begin
          grant   = 1'b1;
          grant_b = bus.b_req && (!bus.a_req || !rr_last);
          state_d = SETUP;
        end
      end
      SETUP: state_d = OPEN;
      OPEN: begin
        if (open_cnt == 4'd0) state_d = HOLD;
      end
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Every output is a register loaded from the next state, so the enables
  // rise and fall exactly on the state boundaries and never glitch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      open_cnt <= 4'd0;
      rr_last  <= 1'b1;
      owner_b  <= 1'b0;
      addr_q   <= '0;
      en_q     <= '0;
      data_q   <= '0;
      a_ack_q  <= 1'b0;
      b_ack_q  <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        addr_q  <= grant_b ? bus.b_addr : bus.a_addr;
        data_q  <= grant_b ? bus.b_data : bus.a_data;
        owner_b <= grant_b;
        rr_last <= grant_b;
      end
      if (state_q == SETUP) begin
        open_cnt <= OPEN_LD;
      end else if (state_q == OPEN && open_cnt != 4'd0) begin
        open_cnt <= open_cnt - 4'd1;
      end
      en_q    <= (state_d == OPEN) ? en_dec : '0;
      a_ack_q <= (state_d == HOLD) && !owner_b;
      b_ack_q <= (state_d == HOLD) && owner_b;
      err_q   <= (state_d == HOLD) && !addr_ok;
      busy_q  <= (state_d != IDLE);
    end
  end

  assign bus.ltch_en   = en_q;
  assign bus.ltch_data = data_q;
  assign bus.a_ack     = a_ack_q;
  assign bus.b_ack     = b_ack_q;
  assign bus.busy      = busy_q;
  assign bus.addr_err  = err_q;
endmodule

// File: tb/tb_ltch_bank_ctrl.sv
// Bench for ltch_bank_ctrl: two instances (OPEN_CYC=1 and 4) checked every
// cycle against a transaction-timeline model, plus directed scenarios.
module tb_ltch_bank_ctrl;
  localparam int DW = 16, NREG = 8, AW = 4;
  localparam int OC0 = 1, OC1 = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ltch_bank_ctrl_if #(.DW(DW), .NREG(NREG), .AW(AW)) bus0();
  ltch_bank_ctrl_if #(.DW(DW), .NREG(NREG), .AW(AW)) bus1();

  ltch_bank_ctrl #(.DW(DW), .NREG(NREG), .AW(AW), .OPEN_CYC(OC0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0));
  ltch_bank_ctrl #(.DW(DW), .NREG(NREG), .AW(AW), .OPEN_CYC(OC1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1));

  // Stimulus arrays, [dut][port] with port 0 = A, 1 = B.
  logic          req   [2][2];
  logic [AW-1:0] addr  [2][2];
  logic [DW-1:0] wdata [2][2];

  assign bus0.a_req = req[0][0];  assign bus0.a_addr = addr[0][0];  assign bus0.a_data = wdata[0][0];
  assign bus0.b_req = req[0][1];  assign bus0.b_addr = addr[0][1];  assign bus0.b_data = wdata[0][1];
  assign bus1.a_req = req[1][0];  assign bus1.a_addr = addr[1][0];  assign bus1.a_data = wdata[1][0];
  assign bus1.b_req = req[1][1];  assign bus1.b_addr = addr[1][1];  assign bus1.b_data = wdata[1][1];

  logic [NREG-1:0] en_o   [2];
  logic [DW-1:0]   data_o [2];
  logic            acka_o [2], ackb_o [2], busy_o [2], err_o [2];

  assign en_o[0] = bus0.ltch_en;  assign data_o[0] = bus0.ltch_data;
  assign acka_o[0] = bus0.a_ack;  assign ackb_o[0] = bus0.b_ack;
  assign busy_o[0] = bus0.busy;   assign err_o[0] = bus0.addr_err;
  assign en_o[1] = bus1.ltch_en;  assign data_o[1] = bus1.ltch_data;
  assign acka_o[1] = bus1.a_ack;  assign ackb_o[1] = bus1.b_ack;
  assign busy_o[1] = bus1.busy;   assign err_o[1] = bus1.addr_err;

  // Reference model: one in-flight write per instance described by its grant
  // edge; every output follows from the offset into the write timeline.
  int            cyc;
  bit            m_active  [2];
  int            m_k       [2];
  bit            m_owner_b [2];
  logic [AW-1:0] m_addr    [2];
  logic [DW-1:0] m_data    [2];
  bit            m_last_b  [2];

  logic [0:0] exp_q0[$], exp_q1[$];
  int         ack_log0[$], ack_log1[$];

  int n_pass, n_total, n_fail;

  function automatic int oc(input int d);
    return (d == 0) ? OC0 : OC1;
  endfunction

  task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s dut%0d cyc=%0d observed=%h expected=%h", tag, d, cyc, obs, exp);
    end
  endtask

  function automatic void expect_of(input int d, output logic [NREG-1:0] e_en,
                                    output logic e_acka, output logic e_ackb,
                                    output logic e_busy, output logic e_err);
    int off;
    int n;
    off    = cyc - m_k[d];
    n      = oc(d);
    e_en   = '0;
    e_acka = 1'b0;
    e_ackb = 1'b0;
    e_busy = 1'b0;
    e_err  = 1'b0;
    if (m_active[d] && off >= 0 && off <= n + 1) begin
      e_busy = 1'b1;
      if (off >= 1 && off <= n && int'(m_addr[d]) < NREG) e_en = NREG'(1 << m_addr[d]);
      if (off == n + 1) begin
        e_acka = !m_owner_b[d];
        e_ackb = m_owner_b[d];
        e_err  = (int'(m_addr[d]) >= NREG);
      end
    end
  endfunction

  function automatic bit model_idle(input int d);
    return !m_active[d] || (cyc >= m_k[d] + oc(d) + 2);
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_active[d] = 1'b0;
      m_k[d]      = 0;
      m_owner_b[d] = 1'b0;
      m_addr[d]   = '0;
      m_data[d]   = '0;
      m_last_b[d] = 1'b1;
    end
    exp_q0.delete();
    exp_q1.delete();
  endtask

  // Decide what the next rising edge does, from the request levels now held.
  task automatic predict();
    bit win_b;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        model_reset();
      end else if (!m_active[d] || (cyc + 1 >= m_k[d] + oc(d) + 3)) begin
        m_active[d] = 1'b0;
        if (req[d][0] || req[d][1]) begin
          if (req[d][0] && req[d][1]) win_b = !m_last_b[d];
          else                         win_b = req[d][1];
          m_active[d]  = 1'b1;
          m_k[d]       = cyc + 1;
          m_owner_b[d] = win_b;
          m_addr[d]    = addr[d][win_b];
          m_data[d]    = wdata[d][win_b];
          m_last_b[d]  = win_b;
          if (d == 0) exp_q0.push_back(win_b);
          else        exp_q1.push_back(win_b);
        end
      end
    end
  endtask

  task automatic check_all();
    logic [NREG-1:0] e_en;
    logic e_acka, e_ackb, e_busy, e_err;
    logic got_b;
    int   depth;
    logic [0:0] expv;
    for (int d = 0; d < 2; d++) begin
      expect_of(d, e_en, e_acka, e_ackb, e_busy, e_err);
      chk("ltch_en",   d, 32'(en_o[d]),   32'(e_en));
      chk("ltch_data", d, 32'(data_o[d]), 32'(m_data[d]));
      chk("a_ack",     d, 32'(acka_o[d]), 32'(e_acka));
      chk("b_ack",     d, 32'(ackb_o[d]), 32'(e_ackb));
      chk("busy",      d, 32'(busy_o[d]), 32'(e_busy));
      chk("addr_err",  d, 32'(err_o[d]),  32'(e_err));
      got_b = (ackb_o[d] === 1'b1);
      if (acka_o[d] === 1'b1 || got_b) begin
        expv = 1'b0;
        if (d == 0) begin
          ack_log0.push_back(int'(got_b));
          depth = exp_q0.size();
          if (depth > 0) expv = exp_q0.pop_front();
        end else begin
          ack_log1.push_back(int'(got_b));
          depth = exp_q1.size();
          if (depth > 0) expv = exp_q1.pop_front();
        end
        chk("sb_pending", d, 32'(depth != 0), 32'(1));
        if (depth > 0) chk("sb_port", d, 32'(got_b), 32'(expv));
      end
    end
  endtask

  task automatic tick();
    predict();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check_all();
  endtask

  task automatic set_req(input int d, input int p, input logic [AW-1:0] a, input logic [DW-1:0] v);
    req[d][p]   = 1'b1;
    addr[d][p]  = a;
    wdata[d][p] = v;
  endtask

  // Requesters drop req on the cycle their ack is (by the model) due.
  task automatic auto_drop();
    logic [NREG-1:0] e_en;
    logic e_acka, e_ackb, e_busy, e_err;
    for (int d = 0; d < 2; d++) begin
      expect_of(d, e_en, e_acka, e_ackb, e_busy, e_err);
      if (e_acka) req[d][0] = 1'b0;
      if (e_ackb) req[d][1] = 1'b0;
    end
  endtask

  task automatic rand_drive();
    logic [NREG-1:0] e_en;
    logic e_acka, e_ackb, e_busy, e_err;
    logic ackp;
    for (int d = 0; d < 2; d++) begin
      expect_of(d, e_en, e_acka, e_ackb, e_busy, e_err);
      for (int p = 0; p < 2; p++) begin
        ackp = (p == 0) ? e_acka : e_ackb;
        if (req[d][p] && ackp) begin
          req[d][p] = 1'b0;
        end else if (req[d][p] && m_active[d] && (int'(m_owner_b[d]) == p) &&
                     cyc == m_k[d] && $urandom_range(0, 7) == 0) begin
          req[d][p] = 1'b0;
        end else if (!req[d][p] && !ackp && $urandom_range(0, 2) == 0) begin
          set_req(d, p, AW'($urandom_range(0, 9)), DW'($urandom));
        end
      end
    end
  endtask

  function automatic bit all_quiet();
    bit q;
    q = 1'b1;
    for (int d = 0; d < 2; d++) begin
      if (req[d][0] || req[d][1] || !model_idle(d)) q = 1'b0;
    end
    return q;
  endfunction

  task automatic drain(input int max, input string tag);
    bit done;
    done = 1'b0;
    for (int i = 0; i < max && !done; i++) begin
      auto_drop();
      done = all_quiet();
      if (!done) tick();
    end
    chk(tag, 0, 32'(all_quiet()), 32'(1));
  endtask

  initial begin
    n_pass = 0; n_total = 0; n_fail = 0; cyc = 0;
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 2; p++) begin
        req[d][p] = 1'b0; addr[d][p] = '0; wdata[d][p] = '0;
      end
    end
    model_reset();

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    chk("reset_en0",   0, 32'(en_o[0]),   32'(0));
    chk("reset_busy1", 1, 32'(busy_o[1]), 32'(0));
    rst = 1'b0;
    tick();

    // Contention from reset: A first, then B
    ack_log0.delete();
    set_req(0, 0, AW'(1), 16'h1111);
    set_req(0, 1, AW'(5), 16'h2222);
    drain(30, "contend1_drain");
    chk("contend1_n",      0, 32'(ack_log0.size()), 32'(2));
    if (ack_log0.size() == 2) begin
      chk("contend1_first",  0, 32'(ack_log0[0]), 32'(0));
      chk("contend1_second", 0, 32'(ack_log0[1]), 32'(1));
    end

    // Single A write (OPEN_CYC=1) alongside B write to word 7 (OPEN_CYC=4)
    set_req(0, 0, AW'(3), 16'hA5A5);
    set_req(1, 1, AW'(7), 16'h1234);
    tick();
    chk("t1_setup_data", 0, 32'(data_o[0]), 32'(16'hA5A5));
    chk("t1_setup_en",   0, 32'(en_o[0]),   32'(0));
    chk("t1_setup_busy", 0, 32'(busy_o[0]), 32'(1));
    chk("t3_setup_data", 1, 32'(data_o[1]), 32'(16'h1234));
    for (int j = 1; j <= 5; j++) begin
      tick();
      chk("t3_en",   1, 32'(en_o[1]),   (j <= 4) ? 32'(8'h80) : 32'(0));
      chk("t3_data", 1, 32'(data_o[1]), 32'(16'h1234));
      chk("t3_ack",  1, 32'(ackb_o[1]), 32'(j == 5));
      if (j == 1) chk("t1_en",   0, 32'(en_o[0]),   32'(8'h08));
      if (j == 2) chk("t1_ack",  0, 32'(acka_o[0]), 32'(1));
      if (j == 3) chk("t1_idle", 0, 32'(busy_o[0]), 32'(0));
      auto_drop();
    end
    drain(20, "t1_drain");

    // Second simultaneous pair after an A win: B first, then A
    ack_log0.delete();
    set_req(0, 0, AW'(0), 16'h3333);
    set_req(0, 1, AW'(6), 16'h4444);
    drain(30, "contend2_drain");
    chk("contend2_n", 0, 32'(ack_log0.size()), 32'(2));
    if (ack_log0.size() == 2) begin
      chk("contend2_first",  0, 32'(ack_log0[0]), 32'(1));
      chk("contend2_second", 0, 32'(ack_log0[1]), 32'(0));
    end

    // Out-of-range address
    set_req(0, 0, AW'(9), 16'hBEEF);
    tick();
    for (int j = 1; j <= 2; j++) begin
      tick();
      chk("oor_en", 0, 32'(en_o[0]), 32'(0));
      if (j == 2) begin
        chk("oor_ack", 0, 32'(acka_o[0]), 32'(1));
        chk("oor_err", 0, 32'(err_o[0]),  32'(1));
      end
    end
    drain(20, "oor_drain");

    // Reset mid-OPEN
    set_req(0, 0, AW'(2), 16'h0F0F);
    tick();
    tick();
    chk("rst_open_en", 0, 32'(en_o[0]), 32'(8'h04));
    rst = 1'b1;
    model_reset();
    for (int d = 0; d < 2; d++) begin
      req[d][0] = 1'b0;
      req[d][1] = 1'b0;
    end
    #1;
    chk("rst_async_en",   0, 32'(en_o[0]),   32'(0));
    chk("rst_async_busy", 0, 32'(busy_o[0]), 32'(0));
    chk("rst_async_ack",  0, 32'(acka_o[0]), 32'(0));
    tick();
    rst = 1'b0;
    ack_log0.delete();
    set_req(0, 0, AW'(2), 16'h0F0F);
    drain(20, "rst_new_drain");
    chk("rst_new_acks", 0, 32'(ack_log0.size()), 32'(1));

    // Early req drop during SETUP
    ack_log1.delete();
    set_req(1, 1, AW'(4), 16'h5A5A);
    tick();
    req[1][1] = 1'b0;
    for (int j = 1; j <= 8; j++) begin
      tick();
      if (j == 5) chk("early_ack", 1, 32'(ackb_o[1]), 32'(1));
      if (j >= 6) chk("early_no_regrant", 1, 32'(busy_o[1]), 32'(0));
      chk("early_data", 1, 32'(data_o[1]), 32'(16'h5A5A));
    end
    chk("early_acks", 1, 32'(ack_log1.size()), 32'(1));

    // Randomized traffic on both instances
    for (int i = 0; i < 800; i++) begin
      rand_drive();
      tick();
    end
    drain(60, "rand_drain");
    chk("sb_empty0", 0, 32'(exp_q0.size()), 32'(0));
    chk("sb_empty1", 1, 32'(exp_q1.size()), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/ltch_bank_ctrl.md
Name: ltch_bank_ctrl

Overview:
- Sequences writes into a bank of NREG latch-based configuration words, each DW bits wide.
- Two requesters share the bank: the APB slave (port A) and the 1553B core (port B). Arbitration is round-robin.
- Each write runs a fixed, glitch-safe sequence: data setup, enable open, then data hold. Exactly one latch enable is driven at a time.
- The block sits between the register-write paths and the latch array. It owns every ltch_en bit and the shared ltch_data bus.

Parameters:
- DW, 16, width of each latch word and of the data buses.
- NREG, 8, number of latch words in the bank; 2..16.
- AW, 4, address width; 2^AW must be >= NREG.
- OPEN_CYC, 1, number of cycles ltch_en stays high per write; 1..15.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- a_req  in  1  port A write request; held high until a_ack.
- a_addr  in  AW  port A target word index.
- a_data  in  DW  port A write data.
- a_ack  out  1  port A one-cycle completion pulse.
- b_req  in  1  port B write request; held high until b_ack.
- b_addr  in  AW  port B target word index.
- b_data  in  DW  port B write data.
- b_ack  out  1  port B one-cycle completion pulse.
- ltch_en  out  NREG  one-hot (or zero) latch enables.
- ltch_data  out  DW  registered data to all latches.
- busy  out  1  high whenever state != IDLE.
- addr_err  out  1  one-cycle pulse with ack when the address is >= NREG.

Behaviour:
- Reset: rst=1 forces, asynchronously, state=IDLE, ltch_en=0, ltch_data=0, a_ack=b_ack=0, busy=0, addr_err=0, rr_last=B. All ltch_en bits drop in the same cycle as rst. A reset mid-write abandons the write with no ack; latch contents are whatever was latched.
- All outputs are registered. No output is combinational from any input.
- FSM states: IDLE, SETUP, OPEN, HOLD.
- IDLE: sampled on each rising edge.
  - No req: stay in IDLE.
  - Only one req: grant it.
  - Both req: grant the port that is not rr_last.
  - On grant: capture addr/data into internal registers, set rr_last=winner, drive ltch_data=captured data, go to SETUP.
- SETUP: 1 cycle. ltch_data is stable, ltch_en=0. Then go to OPEN and load open_cnt=OPEN_CYC-1.
- OPEN: ltch_en[addr]=1 for exactly OPEN_CYC cycles. open_cnt decrements each cycle; leave when it reaches 0.
  - If addr >= NREG, ltch_en stays 0 for the whole state; timing is unchanged.
- HOLD: 1 cycle. ltch_en=0, ltch_data unchanged. Winner's ack=1. addr_err=1 if the address was out of range. Then go to IDLE.
- Timing:
  - Req sampled at edge k gives ack high in cycle k+OPEN_CYC+2.
  - Write cost = OPEN_CYC+3 cycles including IDLE.
  - Back-to-back minimum spacing is OPEN_CYC+3 cycles.
- ltch_data changes only on grant, never during OPEN or HOLD.
- Requester rules:
  - Deassert req on the edge where ack is seen. The IDLE cycle that follows then samples the new req value, so there is no double grant.
  - If req drops before ack, the write still completes with the captured data, and ack is still pulsed.
- The losing requester keeps req high and is granted on the next IDLE sample.
- Fairness: alternating grants under continuous contention; no starvation.
- ltch_en is never multi-hot.
- In PLATFORM_SIM builds, the ltch_en bits feed the team's x-checker, so no X may appear on ltch_en after reset release.

Test Plan:
- Single A write: a_addr=3, a_data=16'hA5A5, OPEN_CYC=1 -> ltch_data=A5A5 in SETUP, ltch_en=8'b0000_1000 for 1 cycle, a_ack pulse 3 cycles after the sampling edge, busy high for 3 cycles.
- Contention: a_req and b_req asserted together from reset (rr_last=B) -> A is granted first, then B. The next simultaneous pair grants B first, then A. Ack order and ltch_en sequence must match.
- OPEN_CYC=4, b_addr=7, b_data=16'h1234 -> ltch_en[7] high for exactly 4 cycles. ltch_data is stable from SETUP through HOLD. b_ack arrives 6 cycles after sampling.
- Out-of-range address: a_addr=9 with NREG=8 -> ltch_en stays 0 throughout; a_ack and addr_err pulse together in the same cycle; normal timing.
- Reset mid-OPEN: assert rst while ltch_en[2]=1 -> ltch_en=0 in the same cycle, no ack issued, state=IDLE after release, and a new request is accepted normally.
- Early req drop: b_req deasserted during SETUP -> the write completes with the original data, b_ack still pulses, and there is no second grant.
